// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Round-robin arbiter sharing one fixed-latency, registered-address
//   instruction ROM between requester 0 (CPU fetch) and requester 1
//   (loader/debug/DMA). The address of the granted requester is muxed onto
//   the ROM. A tag pipeline follows each read through the ROM so that the
//   returned word is steered to the requester that issued it.
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   req0/req1            read requests
//   addr0/addr1          read addresses, held stable while reqN is high
//   gnt0/gnt1            combinational grant, read accepted this cycle
//   rdata0/rdata1        returned data, qualified by rvalid0/rvalid1
//   rvalid0/rvalid1      one-cycle strobe, word for requester N this cycle
//   rom_addr             address presented to the ROM
//   rom_data             data coming back from the ROM
module rom_arbiter #(
    parameter int DEPTH_I     = 8,
    parameter int WIDTH_DATA  = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DEPTH_I-1:0]    addr0,
    input  logic [DEPTH_I-1:0]    addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [WIDTH_DATA-1:0] rdata0,
    output logic [WIDTH_DATA-1:0] rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DEPTH_I-1:0]    rom_addr,
    input  logic [WIDTH_DATA-1:0] rom_data
);

    // Index of the requester granted most recently; resets to 1 so that
    // requester 0 wins the first contention.
    logic                   last_q, last_d;
    // Last issued address, replayed to the ROM on idle cycles.
    logic [DEPTH_I-1:0]     addr_hold_q, addr_hold_d;
    // Tag pipeline: one entry per ROM latency cycle, stage 0 is the youngest.
    logic [ROM_LATENCY-1:0] vld_q, vld_d;
    logic [ROM_LATENCY-1:0] own_q, own_d;

    logic granted;

    // Grants are gated by reset_n so nothing is accepted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && (!req1 || last_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        granted = gnt0 | gnt1;
    end

    always_comb begin
        rom_addr = addr_hold_q;
        if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
        addr_hold_d = rom_addr;
        last_d      = granted ? gnt1 : last_q;
    end

    // Shift the tags one stage per cycle; there is no stall path because the
    // ROM always returns data after a fixed number of cycles.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = granted;
        own_d[0] = gnt1;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 1'b1;
            addr_hold_q <= '0;
            vld_q       <= '0;
            own_q       <= '0;
        end else begin
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            vld_q       <= vld_d;
            own_q       <= own_d;
        end
    end

    // The oldest tag lines up with the word the ROM is presenting now.
    assign rvalid0 = vld_q[ROM_LATENCY-1] & ~own_q[ROM_LATENCY-1];
    assign rvalid1 = vld_q[ROM_LATENCY-1] &  own_q[ROM_LATENCY-1];
    assign rdata0  = rom_data;
    assign rdata1  = rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

    localparam int NI = 3;   // instances with ROM_LATENCY 1, 2, 3

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req0, req1;
    logic [7:0]  addr0, addr1;

    logic [NI-1:0] gnt0_w, gnt1_w, rvalid0_w, rvalid1_w;
    logic [7:0]    rom_addr_w [NI];
    logic [31:0]   rdata0_w [NI];
    logic [31:0]   rdata1_w [NI];
    logic [31:0]   rom_data_w [NI];

    logic [31:0] mem [256];
    int cyc = 0;
    int ntot = 0;
    int npass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
    end

    task automatic chk(input int lat, input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        ntot++;
        if (act === exp_v) npass++;
        else $display("FAIL %s lat=%0d cyc=%0d got=%0h want=%0h", nm, lat, cyc, act, exp_v);
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_lat
        localparam int L = gi + 1;

        rom_arbiter #(.DEPTH_I(8), .WIDTH_DATA(32), .ROM_LATENCY(L)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .req0     (req0),
            .req1     (req1),
            .addr0    (addr0),
            .addr1    (addr1),
            .gnt0     (gnt0_w[gi]),
            .gnt1     (gnt1_w[gi]),
            .rdata0   (rdata0_w[gi]),
            .rdata1   (rdata1_w[gi]),
            .rvalid0  (rvalid0_w[gi]),
            .rvalid1  (rvalid1_w[gi]),
            .rom_addr (rom_addr_w[gi]),
            .rom_data (rom_data_w[gi])
        );

        // Behavioural ROM: address sampled each edge, word appears L cycles later.
        logic [7:0] apipe [4];
        always @(posedge clk) begin
            apipe[0] <= rom_addr_w[gi];
            for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
        end
        assign rom_data_w[gi] = mem[apipe[L-1]];

        exp_t q[$];
        int   last_m = 1;
        int   w_m;
        logic [7:0] hold_m = 8'h00;

        // Reference model: decides the winner, predicts rom_addr, queues the return.
        always @(negedge clk) begin
            if (!reset_n) begin
                chk(L, "rst_gnt", {gnt0_w[gi], gnt1_w[gi]}, 0);
                chk(L, "rst_rom_addr", rom_addr_w[gi], 0);
                q.delete();
                last_m = 1;
                hold_m = 8'h00;
            end else begin
                w_m = -1;
                if (req0 && req1) w_m = (last_m == 0) ? 1 : 0;
                else if (req0)    w_m = 0;
                else if (req1)    w_m = 1;
                chk(L, "gnt0", gnt0_w[gi], (w_m == 0));
                chk(L, "gnt1", gnt1_w[gi], (w_m == 1));
                if (w_m >= 0) begin
                    hold_m = (w_m == 1) ? addr1 : addr0;
                    last_m = w_m;
                    q.push_back('{owner: (w_m == 1), data: mem[hold_m], due: cyc + L});
                end
                chk(L, "rom_addr", rom_addr_w[gi], hold_m);
            end
        end

        // Monitor: pops the expected return whenever a strobe shows up.
        exp_t e;
        always @(negedge clk) begin
            if (!reset_n) begin
                chk(L, "rst_rvalid", {rvalid0_w[gi], rvalid1_w[gi]}, 0);
            end else if (rvalid0_w[gi] || rvalid1_w[gi]) begin
                if (rvalid0_w[gi] && rvalid1_w[gi])
                    chk(L, "rvalid_both", 2'b11, 2'b01);
                else if (q.size() == 0)
                    chk(L, "rvalid_spurious", {rvalid0_w[gi], rvalid1_w[gi]}, 0);
                else begin
                    e = q.pop_front();
                    chk(L, "rv_owner", rvalid1_w[gi], e.owner);
                    chk(L, "rv_cycle", cyc, e.due);
                    chk(L, "rdata", e.owner ? rdata1_w[gi] : rdata0_w[gi], e.data);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk(L, "rvalid_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit g0, g1;

    initial begin
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        // Reset with both requesting: no grants, no returns, rom_addr 0.
        #1 reset_n = 0; req0 = 1; req1 = 1; addr0 = 8'h33; addr1 = 8'h44;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;               // first cycle: requester 0 wins
        tick();                       // requester 1 served next
        req1 = 0; addr0 = 8'h00;      // single requester, address stepping
        for (int a = 1; a < 4; a++) begin
            tick();
            addr0 = a[7:0];
        end
        tick();
        req0 = 0; req1 = 1; addr1 = 8'h7F;   // one grant, then idle hold
        tick();
        req1 = 0;
        repeat (4) tick();
        req0 = 1; addr0 = 8'h10; req1 = 1; addr1 = 8'h20;  // contention
        repeat (6) tick();
        req0 = 0; req1 = 1; addr1 = 8'h55;   // isolated grant to requester 1
        tick();
        req1 = 0;
        repeat (4) tick();
        req1 = 1;                            // back-to-back reads
        for (int a = 1; a < 4; a++) begin
            addr1 = a[7:0];
            tick();
        end
        req1 = 0;
        repeat (4) tick();
        req1 = 1; addr1 = 8'h66;             // reset while a read is in flight
        tick();
        req1 = 0; reset_n = 0;
        tick();
        reset_n = 1;
        repeat (2) tick();
        req0 = 1; req1 = 1;                  // first contention after reset
        tick();
        req0 = 0; req1 = 0;
        repeat (2) tick();
        // Randomised traffic honouring hold-until-grant.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            g0 = gnt0_w[0];
            g1 = gnt1_w[0];
            @(posedge clk);
            #1;
            if (!req0 || g0) begin
                req0 = ($urandom_range(0, 3) != 0);
                addr0 = 8'($urandom);
            end
            if (!req1 || g1) begin
                req1 = ($urandom_range(0, 2) != 0);
                addr1 = 8'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        repeat (8) tick();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
